// File: rtl/eq_solver_pkg.sv
// Shared definitions for the equation-solver start controller and the
// HPS-side PIO map.
//   state_e             FSM state encodings (IDLE/START/RUN/DONE)
//   DEF_SYNC_STAGES     default synchroniser depth for hps_ready
//   DEF_CNT_W           default run-cycle counter width
//   DEF_TIMEOUT_CYCLES  default RUN watchdog limit (used with EQ_SOLVER_TIMEOUT_EN)
package eq_solver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/eq_solver_sync.sv
// Level synchroniser: SYNC_STAGES flop chain, all flops reset to 0.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous, active-low reset
//   d_i      in   asynchronous level
//   q_o      out  d_i delayed by SYNC_STAGES clk cycles
module eq_solver_sync
  import eq_solver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/eq_solver_start_ctrl.sv
// FPGA-side consumer of the HPS "ready" PIO level. Runs a 4-phase handshake:
//   ready rise -> solver start -> solver done -> done flag -> ready fall -> idle.
// Optional feature macro: EQ_SOLVER_TIMEOUT_EN (RUN-state watchdog).
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   hps_ready     in   ready level from HPS PIO (asynchronous to clk)
//   solver_done   in   one-cycle pulse: solve completed
//   solver_start  out  one-cycle start pulse to the solver
//   solver_abort  out  one-cycle abort pulse to the solver
//   fpga_done     out  level: run finished, result valid
//   fpga_error    out  level: last run aborted or timed out
//   cycle_count   out  clk cycles of the last run, START through done inclusive
module eq_solver_start_ctrl
  import eq_solver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hps_ready,
  input  logic             solver_done,
  output logic             solver_start,
  output logic             solver_abort,
  output logic             fpga_done,
  output logic             fpga_error,
  output logic [CNT_W-1:0] cycle_count
);

  logic                   rdy_s;
  logic                   rdy_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sync_ok;
  state_e                 state_q;
  logic                   armed_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   start_q;
  logic                   abort_q;
  logic                   done_q;
  logic                   error_q;
  logic [CNT_W-1:0]       ccount_q;
  logic                   timeout_hit;

  eq_solver_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (hps_ready),
    .q_o    (rdy_s)
  );

  // rdy_s carries reset-fill zeros for the first SYNC_STAGES cycles; arming
  // only on real samples keeps a ready held high through reset from looking
  // like a fresh 0->1 edge.
  assign sync_ok = fill_q[SYNC_STAGES-1];

  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

`ifdef EQ_SOLVER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYCLES);
  assign timeout_hit = (cnt_q >= TimeoutLim);
`else
  // No watchdog in this build; TIMEOUT_CYCLES stays in the parameter list only.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q    <= 1'b0;
      fill_q   <= '0;
      state_q  <= ST_IDLE;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ccount_q <= '0;
    end else begin
      rdy_q   <= rdy_s;
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      start_q <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q && rdy_s && !rdy_q) begin
            state_q <= ST_START;
            start_q <= 1'b1;
            error_q <= 1'b0;
            cnt_q   <= '0;
          end else if (sync_ok && !rdy_s) begin
            armed_q <= 1'b1;
          end
        end
        ST_START: begin
          cnt_q   <= CNT_W'(1);
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          cnt_q <= cnt_inc;
          if (solver_done) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            ccount_q <= cnt_inc;
          end else if (!rdy_s) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b1;
            error_q <= 1'b1;
            armed_q <= 1'b0;
          end else if (timeout_hit) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            abort_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!rdy_s) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            armed_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign solver_start = start_q;
  assign solver_abort = abort_q;
  assign fpga_done    = done_q;
  assign fpga_error   = error_q;
  assign cycle_count  = ccount_q;

endmodule
